// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receive front-end.
// Synchronises and de-glitches the raw PS/2 lines, deserialises 11-bit
// device-to-host frames, strips E0/F0/E1 prefixes and presents one clean
// key event per press/release to the downstream keyboard_wb block.
//
// Ports:
//   clk          system clock (wb_clk, 4 MHz)
//   reset        synchronous, active-high reset
//   ps2_clk      raw PS/2 clock (asynchronous)
//   ps2_data     raw PS/2 data (asynchronous)
//   key_valid    one-cycle strobe: new event on key_code/key_ext/key_release
//   key_code     set-2 scan code of the last event (held)
//   key_ext      last event was E0-prefixed
//   key_release  last event was F0-prefixed
//   frame_err    one-cycle strobe on parity/stop error or timeout abort
//   busy         frame reception in progress
module ps2_kbd_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 4000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic       frame_err,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [3:0]    CNT_LAST = 4'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} rx_state_t;

  // synchronisers
  logic clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  // glitch filters and edge detect
  logic       clk_f_q, clk_f_d, dat_f_q, dat_f_d, clk_prev_q, clk_prev_d;
  logic [3:0] clk_cnt_q, clk_cnt_d, dat_cnt_q, dat_cnt_d;
  logic       fall;
  // receiver
  rx_state_t      state_q, state_d;
  logic [2:0]     bitcnt_q, bitcnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [7:0]     byte_q, byte_d;
  logic           byte_vld_q, byte_vld_d;
  logic           err_q, err_d;
  // decoder
  logic           kv_q, kv_d;
  logic [7:0]     code_q, code_d;
  logic           kext_q, kext_d, krel_q, krel_d;
  logic           ext_q, ext_d, rel_q, rel_d;
  logic [2:0]     skip_q, skip_d;

  always_comb begin
    clk_s1_d   = ps2_clk;
    clk_s2_d   = clk_s1_q;
    dat_s1_d   = ps2_data;
    dat_s2_d   = dat_s1_q;
    clk_prev_d = clk_f_q;

    // Count consecutive samples disagreeing with the filtered value; any
    // agreeing sample restarts the count.
    clk_f_d   = clk_f_q;
    clk_cnt_d = '0;
    if (clk_s2_q != clk_f_q) begin
      if (clk_cnt_q == CNT_LAST) clk_f_d = clk_s2_q;
      else                       clk_cnt_d = clk_cnt_q + 4'd1;
    end
    dat_f_d   = dat_f_q;
    dat_cnt_d = '0;
    if (dat_s2_q != dat_f_q) begin
      if (dat_cnt_q == CNT_LAST) dat_f_d = dat_s2_q;
      else                       dat_cnt_d = dat_cnt_q + 4'd1;
    end
  end

  assign fall = clk_prev_q & ~clk_f_q;

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    byte_d     = byte_q;
    byte_vld_d = 1'b0;
    err_d      = 1'b0;

    if (state_q == S_IDLE || fall) tmo_d = '0;
    else                           tmo_d = tmo_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (fall && !dat_f_q) begin
          state_d  = S_DATA;
          bitcnt_d = '0;
        end
      end
      S_DATA: begin
        if (fall) begin
          shift_d  = {dat_f_q, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (fall) begin
          par_d   = dat_f_q;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (fall) begin
          state_d = S_IDLE;
          if (dat_f_q && (^{shift_q, par_q})) begin
            byte_d     = shift_q;
            byte_vld_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE && !fall && tmo_q == TMO_LAST) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
      tmo_d   = '0;
    end
  end

  always_comb begin
    kv_d   = 1'b0;
    code_d = code_q;
    kext_d = kext_q;
    krel_d = krel_q;
    ext_d  = ext_q;
    rel_d  = rel_q;
    skip_d = skip_q;

    // err_q and byte_vld_q are mutually exclusive: one STOP yields one or the other.
    if (err_q) begin
      ext_d  = 1'b0;
      rel_d  = 1'b0;
      skip_d = '0;
    end else if (byte_vld_q) begin
      if (skip_q != 3'd0) begin
        skip_d = skip_q - 3'd1;
      end else if (byte_q == 8'hE1) begin
        kv_d   = 1'b1;
        code_d = 8'hE1;
        kext_d = 1'b0;
        krel_d = 1'b0;
        ext_d  = 1'b0;
        rel_d  = 1'b0;
        skip_d = 3'd7;
      end else if (byte_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (byte_q == 8'hF0) begin
        rel_d = 1'b1;
      end else if (!ext_q && (byte_q == 8'hFA || byte_q == 8'hAA ||
                              byte_q == 8'hEE || byte_q == 8'hFE ||
                              byte_q == 8'h00 || byte_q == 8'hFF)) begin
        ext_d = 1'b0;
        rel_d = 1'b0;
      end else begin
        kv_d   = 1'b1;
        code_d = byte_q;
        kext_d = ext_q;
        krel_d = rel_q;
        ext_d  = 1'b0;
        rel_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      clk_f_q    <= 1'b1;
      dat_f_q    <= 1'b1;
      clk_prev_q <= 1'b1;
      clk_cnt_q  <= '0;
      dat_cnt_q  <= '0;
      state_q    <= S_IDLE;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      byte_q     <= '0;
      byte_vld_q <= 1'b0;
      err_q      <= 1'b0;
      kv_q       <= 1'b0;
      code_q     <= '0;
      kext_q     <= 1'b0;
      krel_q     <= 1'b0;
      ext_q      <= 1'b0;
      rel_q      <= 1'b0;
      skip_q     <= '0;
    end else begin
      clk_s1_q   <= clk_s1_d;
      clk_s2_q   <= clk_s2_d;
      dat_s1_q   <= dat_s1_d;
      dat_s2_q   <= dat_s2_d;
      clk_f_q    <= clk_f_d;
      dat_f_q    <= dat_f_d;
      clk_prev_q <= clk_prev_d;
      clk_cnt_q  <= clk_cnt_d;
      dat_cnt_q  <= dat_cnt_d;
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      byte_q     <= byte_d;
      byte_vld_q <= byte_vld_d;
      err_q      <= err_d;
      kv_q       <= kv_d;
      code_q     <= code_d;
      kext_q     <= kext_d;
      krel_q     <= krel_d;
      ext_q      <= ext_d;
      rel_q      <= rel_d;
      skip_q     <= skip_d;
    end
  end

  assign key_valid   = kv_q;
  assign key_code    = code_q;
  assign key_ext     = kext_q;
  assign key_release = krel_q;
  assign frame_err   = err_q;
  assign busy        = (state_q != S_IDLE);

endmodule
